// File: rtl/sap1_pkg.sv
// Shared constants and types for the SAP-1 run-control sequencer.
package sap1_pkg;

  localparam int OPC_W      = 4;
  localparam int STEP_W     = 3;
  localparam int CW_W       = 14;
  localparam int ADDR_W     = OPC_W + STEP_W;
  localparam int MEM_RD_BIT = 10;

  localparam logic [STEP_W-1:0] LAST_STEP   = 3'd4;
  localparam logic [STEP_W-1:0] DECODE_STEP = 3'd2;
  localparam logic [OPC_W-1:0]  HLT_OPCODE  = 4'b1111;
  localparam logic [CW_W-1:0]   CW_NOP      = 14'b00111110000011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

// File: rtl/sap1_microsequencer_step_counter.sv
// T-state counter: wraps after LAST_STEP, holds while stalled, clears on halt/early end.
module sap1_step_counter
  import sap1_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              hold,
  input  logic              clear,
  output logic [STEP_W-1:0] step,
  output logic              last
);

  assign last = (step == LAST_STEP);

  // An out-of-range encoding recovers to 0 even while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step <= '0;
    end else if (step > LAST_STEP) begin
      step <= '0;
    end else if (hold) begin
      step <= step;
    end else if (clear) begin
      step <= '0;
    end else if (run) begin
      step <= last ? '0 : step + 1'b1;
    end
  end

endmodule

// File: rtl/sap1_microsequencer.sv
// SAP-1 run-control sequencer: IDLE/RUN/HALT FSM, microcode addressing and cw gating.
// Optional macro SAP1_EARLY_END_EN ends an instruction at the first NOP word from step 2 on.
module sap1_microsequencer
  import sap1_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              mem_ready,
  input  logic [CW_W-1:0]   rom_cw,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [CW_W-1:0]   cw_bus,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              halted,
  output logic              instr_done
);

  state_t state, state_next;
  logic   running;
  logic   stall;
  logic   halt_hit;
  logic   early_end;
  logic   last;

  assign running  = (state == RUN);
  assign stall    = running && rom_cw[MEM_RD_BIT] && !mem_ready;
  assign halt_hit = running && !stall && (step == DECODE_STEP) && (opcode == HLT_OPCODE);
  assign rom_addr = {opcode, step};

`ifdef SAP1_EARLY_END_EN
  assign early_end = running && !stall && (step >= DECODE_STEP) && (rom_cw == CW_NOP);
`else
  assign early_end = 1'b0;
`endif

  sap1_step_counter u_step_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (running),
    .hold  (stall),
    .clear (halt_hit || early_end),
    .step  (step),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Only reset leaves RUN for IDLE; a held start resumes from HALT at once.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    halted     = 1'b0;
    instr_done = 1'b0;
    cw_bus     = CW_NOP;
    unique case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (!stall) begin
          cw_bus     = rom_cw;
          instr_done = last || early_end;
        end
        if (halt_hit) state_next = HALT;
      end
      HALT: begin
        halted = 1'b1;
        if (start) state_next = RUN;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sap1_microsequencer.sv
// Directed self-checking bench for sap1_microsequencer with a small microcode ROM model.
module tb_sap1_microsequencer;

  localparam logic [13:0] NOP_WORD = 14'b00111110000011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  opcode;
  logic        mem_ready;
  logic [13:0] rom_cw;
  logic [6:0]  rom_addr;
  logic [13:0] cw_bus;
  logic [2:0]  step;
  logic        busy;
  logic        halted;
  logic        instr_done;

  logic        rd_en;
  logic [2:0]  rd_step;
  logic        nop_en;
  logic [6:0]  nop_addr;

  int checks   = 0;
  int failures = 0;

  sap1_microsequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .rom_cw     (rom_cw),
    .rom_addr   (rom_addr),
    .cw_bus     (cw_bus),
    .step       (step),
    .busy       (busy),
    .halted     (halted),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  // ROM word: bit 13 plus the address, optional memory-read bit, optional NOP slot.
  function automatic logic [13:0] rom_word(input logic [6:0] a, input logic re,
                                           input logic [2:0] rs, input logic ne,
                                           input logic [6:0] na);
    logic [13:0] w;
    w = 14'h2000 | {7'd0, a};
    if (re && a[2:0] == rs) w[10] = 1'b1;
    if (ne && a == na) w = NOP_WORD;
    return w;
  endfunction

  assign rom_cw = rom_word(rom_addr, rd_en, rd_step, nop_en, nop_addr);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic rd, input logic [2:0] rs,
                               input logic mr);
    @(negedge clk);
    rst_n     = 1'b0;
    start     = 1'b0;
    opcode    = op;
    rd_en     = rd;
    rd_step   = rs;
    nop_en    = 1'b0;
    nop_addr  = 7'd0;
    mem_ready = mr;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkRun(input string tag, input logic [2:0] s, input logic d, input logic [3:0] op);
    checkOutput({tag, "_step"}, 32'(step), 32'(s));
    checkOutput({tag, "_done"}, 32'(instr_done), 32'(d));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_cw"}, 32'(cw_bus), 32'(rom_word({op, s}, rd_en, rd_step, nop_en, nop_addr)));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = 4'b0001; mem_ready = 1'b1;
    rd_en = 1'b0; rd_step = 3'd0; nop_en = 1'b0; nop_addr = 7'd0;
    #3;
    checkOutput("rst_step", 32'(step), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_done", 32'(instr_done), 32'd0);
    checkOutput("rst_cw", 32'(cw_bus), 32'(NOP_WORD));

    // Plain instruction: 0,1,2,3,4,0 with done only at step 4.
    applyStimulus(4'b0001, 1'b0, 3'd0, 1'b1);
    checkOutput("idle_cw", 32'(cw_bus), 32'(NOP_WORD));
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      checkRun("seq", 3'(i % 5), (i == 4), 4'b0001);
      if (i == 4) checkOutput("seq_addr", 32'(rom_addr), 32'b0001100);
    end
    start = 1'b0;

    // Halt after step 2, hold 10 cycles, resume on start.
    applyStimulus(4'b1111, 1'b0, 3'd0, 1'b1);
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    checkRun("hlt0", 3'd0, 1'b0, 4'b1111);
    nextCycle();
    checkRun("hlt1", 3'd1, 1'b0, 4'b1111);
    nextCycle();
    checkRun("hlt2", 3'd2, 1'b0, 4'b1111);
    checkOutput("hlt2_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      checkOutput("halt_halted", 32'(halted), 32'd1);
      checkOutput("halt_busy", 32'(busy), 32'd0);
      checkOutput("halt_step", 32'(step), 32'd0);
      checkOutput("halt_cw", 32'(cw_bus), 32'(NOP_WORD));
    end
    start = 1'b1;
    opcode = 4'b0001;
    nextCycle();
    start = 1'b0;
    checkRun("resume0", 3'd0, 1'b0, 4'b0001);
    checkOutput("resume_halted", 32'(halted), 32'd0);
    nextCycle();
    checkRun("resume1", 3'd1, 1'b0, 4'b0001);

    // Memory-read stall at step 1 for three cycles.
    applyStimulus(4'b0001, 1'b1, 3'd1, 1'b0);
    start = 1'b1;
    nextCycle();
    checkRun("stl0", 3'd0, 1'b0, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("stall_step", 32'(step), 32'd1);
      checkOutput("stall_cw", 32'(cw_bus), 32'(NOP_WORD));
      checkOutput("stall_done", 32'(instr_done), 32'd0);
      checkOutput("stall_busy", 32'(busy), 32'd1);
    end
    mem_ready = 1'b1;
    #1;
    checkOutput("unstall_cw", 32'(cw_bus), 32'(14'h2000 | 14'h0400 | 14'h0009));
    nextCycle();
    checkRun("unstall2", 3'd2, 1'b0, 4'b0001);
    start = 1'b0;

    // Asynchronous reset in the middle of step 3.
    applyStimulus(4'b0001, 1'b0, 3'd0, 1'b1);
    start = 1'b1;
    for (int i = 0; i < 4; i++) nextCycle();
    start = 1'b0;
    checkRun("pre_arst", 3'd3, 1'b0, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_step", 32'(step), 32'd0);
    checkOutput("arst_cw", 32'(cw_bus), 32'(NOP_WORD));
    checkOutput("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_step", 32'(step), 32'd0);
    end

    // NOP word at step 3 of opcode 1110.
    applyStimulus(4'b1110, 1'b0, 3'd0, 1'b1);
    nop_en = 1'b1;
    nop_addr = 7'b1110011;
    start = 1'b1;
    for (int i = 0; i < 4; i++) nextCycle();
    start = 1'b0;
    checkOutput("ee_step", 32'(step), 32'd3);
    checkOutput("ee_cw", 32'(cw_bus), 32'(NOP_WORD));
`ifdef SAP1_EARLY_END_EN
    checkOutput("ee_done", 32'(instr_done), 32'd1);
    nextCycle();
    checkOutput("ee_next", 32'(step), 32'd0);
`else
    checkOutput("ee_done", 32'(instr_done), 32'd0);
    nextCycle();
    checkOutput("ee_next", 32'(step), 32'd4);
`endif

    // Stall and halt collide at step 2.
    applyStimulus(4'b1111, 1'b1, 3'd2, 1'b0);
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("col_step", 32'(step), 32'd2);
    checkOutput("col_cw", 32'(cw_bus), 32'(NOP_WORD));
    nextCycle();
    checkOutput("col_hold_step", 32'(step), 32'd2);
    checkOutput("col_hold_halted", 32'(halted), 32'd0);
    checkOutput("col_hold_busy", 32'(busy), 32'd1);
    mem_ready = 1'b1;
    nextCycle();
    checkOutput("col_halted", 32'(halted), 32'd1);
    checkOutput("col_busy", 32'(busy), 32'd0);
    checkOutput("col_step0", 32'(step), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sap1_microsequencer.md
Name: sap1_microsequencer

Overview:
- Run-control sequencer for the SAP-1 microcoded core.
- Owns the T-state (step) counter and drives the 7-bit microcode ROM address {opcode, step}.
- Gates the ROM's 14-bit control word onto cw_bus, and stalls on memory-not-ready.
- Handles start, halt and instruction-complete signalling, replacing the free-running step counter.

Parameters:
- OPC_W, 4, opcode width.
- STEP_W, 3, step counter width.
- CW_W, 14, control word width.
- LAST_STEP, 4, final T-state index; the step wraps to 0 after it.
- HLT_OPCODE, 4'b1111, opcode that halts the core.
- MEM_RD_BIT, 10, cw bit index that marks a memory-read T-state, subject to stall.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; leaves IDLE or HALT.
- opcode  in  OPC_W  current instruction register opcode.
- mem_ready  in  1  RAM data valid this cycle.
- rom_cw  in  CW_W  control word read from the microcode ROM at rom_addr.
- rom_addr  out  OPC_W+STEP_W  {opcode, step}, combinational.
- cw_bus  out  CW_W  control word to the datapath.
- step  out  STEP_W  current T-state.
- busy  out  1  high in RUN.
- halted  out  1  high in HALT.
- instr_done  out  1  one-cycle pulse on the last T-state of an instruction.

Behaviour:
- Reset: asynchronous, active-low, one clock domain (clk).
  - While rst_n=0: state=IDLE, step=0, busy=0, halted=0, instr_done=0.
  - cw_bus=CW_NOP (14'b00111110000011).
- FSM states and transitions:
  - IDLE -> RUN when start=1; step stays 0.
  - RUN -> HALT when step==2 and opcode==HLT_OPCODE. HALT is entered on the next edge with step=0. No T-states 3..LAST_STEP are issued.
  - HALT -> RUN when start=1. The rising edge of start is not required; a held start resumes immediately.
  - RUN has no exit to IDLE; only reset returns to IDLE.
- cw_bus:
  - Equals rom_cw only in RUN and not stalled.
  - Otherwise equals CW_NOP: in IDLE, in HALT, and in every stall cycle.
- Stall:
  - Condition: in RUN with rom_cw[MEM_RD_BIT]=1 and mem_ready=0.
  - While stalled: step holds, cw_bus=CW_NOP, instr_done=0.
  - No timeout.
  - Stall has priority over halt detection and the step advance.
- Step advance in RUN, when not stalled:
  - If step==LAST_STEP: step<=0 and instr_done=1 this cycle.
  - Otherwise step<=step+1.
- Latency:
  - Each T-state lasts 1 cycle plus any stall cycles.
  - A non-halting instruction takes LAST_STEP+1 = 5 cycles without stalls.
- The opcode is sampled combinationally every cycle. The IR must be stable from step 2 onward, which the fetch microcode guarantees.
- Reset mid-instruction: immediate return to IDLE, step=0, cw_bus=CW_NOP. No partial state is retained.
- Step never exceeds LAST_STEP. Any illegal encoding forces step to 0.

Optional Feature:
- Macro: SAP1_EARLY_END_EN.
- Defined:
  - In RUN at step>=2, not stalled, with rom_cw==CW_NOP: the instruction ends this cycle.
  - step<=0 and instr_done=1, skipping the trailing NOP T-states.
  - Example: an LDA ending with a NOP at step 4 is unchanged, but an OUT instruction ends at step 3.
  - Fetch steps 0 and 1 are never shortened.
- Undefined: always LAST_STEP+1 T-states per instruction.

Decomposition:
- Package sap1_pkg holds:
  - state enum {IDLE, RUN, HALT};
  - CW_NOP;
  - HLT_OPCODE;
  - MEM_RD_BIT;
  - width constants.
- One natural sub-module, sap1_step_counter: a mod-(LAST_STEP+1) counter with hold (stall) and synchronous clear (halt or early end) inputs, plus the async rst_n.
- The FSM and cw gating stay in the top level.

Test Plan:
- Reset, then start=1, opcode=4'b0001, mem_ready=1: step goes 0,1,2,3,4,0, with instr_done=1 only in the step-4 cycle and rom_addr=7'b0001100 at step 4.
- opcode=4'b1111 after start: steps 0,1,2 issue, then halted=1 and busy=0 from the next cycle. cw_bus=CW_NOP and step=0 hold for 10 cycles. Pulsing start resumes at step 0.
- rom_cw[10]=1 at step 1 with mem_ready=0 for 3 cycles: step stays 1 for 3 cycles with cw_bus=CW_NOP, then advances to 2 one cycle after mem_ready=1.
- Assert rst_n=0 asynchronously mid-cycle at step 3: step=0, cw_bus=CW_NOP and busy=0 before the next clk edge. The block stays in IDLE until start.
- With SAP1_EARLY_END_EN and rom_cw=CW_NOP at step 3 (opcode 4'b1110): instr_done=1 at step 3 and the next cycle is step 0. Without the macro, step 4 is issued.
- Stall and halt collide at step 2 (opcode 4'b1111, rom_cw[10]=1, mem_ready=0): no halt while stalled. Halt is taken on the first cycle with mem_ready=1.
